// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants and the Set-2 scan-code to ASCII translation.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    function automatic logic [7:0] scan2ascii(input logic [7:0] code);
        logic [7:0] ascii;
        // NOTE: assigning a default before the case keeps every caller latch-free.
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = "a";
            8'h32: ascii = "b";
            8'h21: ascii = "c";
            8'h23: ascii = "d";
            8'h24: ascii = "e";
            8'h2B: ascii = "f";
            8'h34: ascii = "g";
            8'h33: ascii = "h";
            8'h43: ascii = "i";
            8'h3B: ascii = "j";
            8'h42: ascii = "k";
            8'h4B: ascii = "l";
            8'h3A: ascii = "m";
            8'h31: ascii = "n";
            8'h44: ascii = "o";
            8'h4D: ascii = "p";
            8'h15: ascii = "q";
            8'h2D: ascii = "r";
            8'h1B: ascii = "s";
            8'h2C: ascii = "t";
            8'h3C: ascii = "u";
            8'h2A: ascii = "v";
            8'h1D: ascii = "w";
            8'h22: ascii = "x";
            8'h35: ascii = "y";
            8'h1A: ascii = "z";
            8'h45: ascii = "0";
            8'h16: ascii = "1";
            8'h1E: ascii = "2";
            8'h26: ascii = "3";
            8'h25: ascii = "4";
            8'h2E: ascii = "5";
            8'h36: ascii = "6";
            8'h3D: ascii = "7";
            8'h3E: ascii = "8";
            8'h46: ascii = "9";
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            default: ascii = 8'h00;
        endcase
        return ascii;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: synchroniser, falling-edge detect, 11-bit framing and odd-parity check.
// Define PS2_TIMEOUT_EN to add a watchdog that abandons stalled partial frames.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3
`ifdef PS2_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       timeout_o
);

    localparam int                CNT_W    = $clog2(PS2_FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   fall;
    logic                   data_bit;
    logic                   timeout;

    // Sync flops reset low so a line held low across reset cannot fake an edge.
    assign fall     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_bit = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        if (fall) begin
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                // shift_q holds start, d0..d7, parity; data_bit is the stop bit.
                if (!shift_q[0] && data_bit && (^shift_q[9:1])) begin
                    byte_valid_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = {data_bit, shift_q[9:1]};
            end
        end
        if (timeout) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= '0;
            data_sync_q  <= '0;
            clk_prev_q   <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let the chain shift one stage per clk.
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        timeout = 1'b0;
        if (fall || (bit_cnt_q == '0)) begin
            timer_d = '0;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            timer_d = '0;
            timeout = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // The shifter only moves on the next edge, so the byte stays stable under byte_valid.
    assign byte_o       = shift_q[8:1];
    assign byte_valid_o = byte_valid_q;
    assign timeout_o    = timeout;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: make/break decoder on top of ps2_frame_rx.
// Define PS2_TIMEOUT_EN to enable the partial-frame watchdog.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3
`ifdef PS2_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_scanout,
    output logic [7:0] ps2_out,
    output logic       putdown
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       timeout;

    logic [7:0] scan_q, scan_d;
    logic [7:0] ascii_q, ascii_d;
    logic       held_q, held_d;
    logic       break_pending_q, break_pending_d;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES)
`ifdef PS2_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .timeout_o    (timeout)
    );

    // Extended prefix E0 falls through untouched; the code after it decodes normally.
    always_comb begin
        scan_d          = scan_q;
        ascii_d         = ascii_q;
        held_d          = held_q;
        break_pending_d = break_pending_q;
        if (byte_valid) begin
            if (rx_byte == PS2_BREAK) begin
                break_pending_d = 1'b1;
            end else if (rx_byte != PS2_EXT) begin
                if (break_pending_q) begin
                    break_pending_d = 1'b0;
                    if (rx_byte == scan_q) begin
                        held_d = 1'b0;
                    end
                end else begin
                    scan_d  = rx_byte;
                    ascii_d = scan2ascii(rx_byte);
                    held_d  = 1'b1;
                end
            end
        end
        if (timeout) begin
            break_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q          <= 8'h00;
            ascii_q         <= 8'h00;
            held_q          <= 1'b0;
            break_pending_q <= 1'b0;
        end else begin
            scan_q          <= scan_d;
            ascii_q         <= ascii_d;
            held_q          <= held_d;
            break_pending_q <= break_pending_d;
        end
    end

    assign ps2_scanout = scan_q;
    assign ps2_out     = ascii_q;
    assign putdown     = held_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed scoreboard bench for ps2_keyboard_rx: expected output states are queued per step
// and compared once the frame has settled through the synchroniser and decoder.
module tb_ps2_keyboard_rx;

    localparam int CLK_NS      = 10;
    localparam int HALF_CLKS   = 10;
    localparam int SYNC_STAGES = 3;
`ifdef PS2_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 200;
`endif

    typedef struct {
        logic [7:0] scan;
        logic [7:0] ascii;
        logic       held;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ps2_scanout;
    logic [7:0] ps2_out;
    logic       putdown;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    ps2_keyboard_rx #(
        .SYNC_STAGES    (SYNC_STAGES)
`ifdef PS2_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_scanout (ps2_scanout),
        .ps2_out     (ps2_out),
        .putdown     (putdown)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] scan, input logic [7:0] ascii, input logic held);
        exp_t e;
        e.scan  = scan;
        e.ascii = ascii;
        e.held  = held;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".scan"}, ps2_scanout, e.scan);
            check({tag, ".ascii"}, ps2_out, e.ascii);
            check({tag, ".held"}, {7'b0, putdown}, {7'b0, e.held});
        end
    endtask

    // Drives the low nbits of frame LSB first; data changes while ps2_clk is high.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            repeat (HALF_CLKS) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF_CLKS) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] data, input bit good_parity);
        logic par;
        par = good_parity ? ~(^data) : (^data);
        send_bits({1'b1, par, data, 1'b0}, 11);
        repeat (SYNC_STAGES + 4) @(posedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        expect_out(8'h00, 8'h00, 1'b0);
        check_out("reset");
        rst = 1'b0;
        repeat (10) @(posedge clk);

        expect_out(8'h1C, 8'h61, 1'b1);
        send_byte(8'h1C, 1'b1);
        check_out("make_1c");

        expect_out(8'h1C, 8'h61, 1'b1);
        send_byte(8'hF0, 1'b1);
        check_out("break_prefix");
        expect_out(8'h1C, 8'h61, 1'b0);
        send_byte(8'h1C, 1'b1);
        check_out("release_1c");

        expect_out(8'h1C, 8'h61, 1'b0);
        send_byte(8'h16, 1'b0);
        check_out("bad_parity_16");
        expect_out(8'h16, 8'h31, 1'b1);
        send_byte(8'h16, 1'b1);
        check_out("make_16");

        expect_out(8'h1C, 8'h61, 1'b1);
        send_byte(8'h1C, 1'b1);
        check_out("press_1c");
        expect_out(8'h32, 8'h62, 1'b1);
        send_byte(8'h32, 1'b1);
        check_out("press_32");
        send_byte(8'hF0, 1'b1);
        expect_out(8'h32, 8'h62, 1'b1);
        send_byte(8'h1C, 1'b1);
        check_out("release_other");
        send_byte(8'hF0, 1'b1);
        expect_out(8'h32, 8'h62, 1'b0);
        send_byte(8'h32, 1'b1);
        check_out("release_32");

        expect_out(8'h32, 8'h62, 1'b0);
        send_byte(8'hE0, 1'b1);
        check_out("ext_prefix");
        expect_out(8'h75, 8'h00, 1'b1);
        send_byte(8'h75, 1'b1);
        check_out("ext_75");

        send_bits(11'b000_0101_0110, 5);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        expect_out(8'h00, 8'h00, 1'b0);
        check_out("rst_mid_frame");
        rst = 1'b0;
        repeat (10) @(posedge clk);
        expect_out(8'h29, 8'h20, 1'b1);
        send_byte(8'h29, 1'b1);
        check_out("after_rst_29");
        expect_out(8'h29, 8'h20, 1'b1);
        send_byte(8'h29, 1'b1);
        check_out("typematic_29");

        expect_out(8'h5A, 8'h0D, 1'b1);
        send_byte(8'h5A, 1'b1);
        check_out("enter_5a");
        expect_out(8'h66, 8'h08, 1'b1);
        send_byte(8'h66, 1'b1);
        check_out("bksp_66");
        expect_out(8'h45, 8'h30, 1'b1);
        send_byte(8'h45, 1'b1);
        check_out("digit_45");

        // Partial frame followed by a long stall, then a complete 0x29 frame.
        send_bits(11'b000_0001_1010, 5);
        repeat (300) @(posedge clk);
`ifdef PS2_TIMEOUT_EN
        expect_out(8'h29, 8'h20, 1'b1);
`else
        expect_out(8'h45, 8'h30, 1'b1);
`endif
        send_byte(8'h29, 1'b1);
        check_out("stall_then_29");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver. It deserialises Set-2 scan-code frames from a PS/2 device and tracks the make/break state of the current key. It translates the latest make code to ASCII. Outputs drive the seven-segment display path: scan code on the low byte, ASCII on the high byte, key-held flag on the segment enable.

Parameters:
SYNC_STAGES, 3, flops in the ps2_clk/ps2_data synchroniser chain (minimum 2).
TIMEOUT_CYCLES, 50000, idle clk cycles before a partial frame is abandoned (used only with the optional feature).

Ports:
clk  input  1  system clock; all logic is synchronous to its rising edge.
rst  input  1  reset, asynchronous, active-high.
ps2_clk  input  1  raw PS/2 clock from the device.
ps2_data  input  1  raw PS/2 data from the device.
ps2_scanout  output  8  last accepted make scan code.
ps2_out  output  8  ASCII of ps2_scanout; 0x00 if unmapped.
putdown  output  1  1 while the key in ps2_scanout is held.

Behaviour:
- Reset: ps2_scanout=0x00, ps2_out=0x00, putdown=0, bit counter=0, shift register=0, break_pending=0.
- Synchronisation: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is the previous synchronised ps2_clk=1 and the current one=0.
- Frame format: 11 bits, LSB first: start(0), d0..d7, parity, stop(1). One bit is sampled per falling edge. The bit counter runs 0..10.
- On the 11th sample:
  - The counter returns to 0.
  - The frame is valid iff start=0, stop=1, and d0..d7 plus parity have odd parity.
  - A valid frame produces a one-clk byte_valid pulse.
  - An invalid frame is silently dropped with no output change.
- Decoder, acting on byte_valid; outputs are registered and update on the clk edge after byte_valid:
  - Byte 0xE0: ignored as an extended prefix. No state change.
  - Byte 0xF0: break_pending=1.
  - Any other byte with break_pending=1:
    - break_pending is cleared.
    - If the byte equals ps2_scanout, putdown=0.
    - Otherwise putdown is unchanged.
    - ps2_scanout and ps2_out always hold.
  - Any other byte with break_pending=0: this is a make code. ps2_scanout=byte, ps2_out=ascii(byte), putdown=1.
  - Typematic repeat of the same make code leaves the outputs unchanged in value.
- ASCII map:
  - Set-2 letters map to lowercase: 0x1C→'a', 0x32→'b', 0x21→'c', 0x23→'d', 0x24→'e', ... 0x1A→'z'.
  - Digits: 0x45→'0', 0x16→'1', 0x1E→'2', 0x26→'3', 0x25→'4', 0x2E→'5', 0x36→'6', 0x3D→'7', 0x3E→'8', 0x46→'9'.
  - 0x29→0x20 (space), 0x5A→0x0D (enter), 0x66→0x08 (backspace).
  - All other codes map to 0x00.
- Latency: outputs change no more than SYNC_STAGES+2 clk cycles after the stop-bit falling edge on the raw ps2_clk.
- Reset mid-frame discards the partial frame. The first falling edge after reset is treated as a start bit.
- ps2_clk is assumed slower than clk/8. No inhibit/host-to-device transmission is supported.

Optional Feature:
PS2_TIMEOUT_EN.
- Defined: a counter clears on every falling edge and increments while the bit counter ≠ 0. On reaching TIMEOUT_CYCLES, the bit counter and shift register reset to 0 and break_pending is cleared. The feature recovers from glitches and lost bits.
- Undefined: there is no watchdog. A partial frame waits indefinitely for its remaining edges.

Decomposition:
- Package ps2_pkg holds:
  - Constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_FRAME_BITS=11.
  - Function scan2ascii (the ASCII map above).
- Sub-module ps2_frame_rx holds the synchroniser, edge detect, bit counter, parity check, optional timeout, and outputs the byte plus byte_valid.
- The top level holds the make/break decoder.

Test Plan:
- Reset, then send frame 0x1C (valid parity) → ps2_scanout=0x1C, ps2_out=0x61, putdown=1.
- Send 0xF0 then 0x1C → putdown=0, ps2_scanout stays 0x1C, ps2_out stays 0x61.
- Send 0x16 with bad parity → no output change. Then a valid 0x16 → ps2_scanout=0x16, ps2_out=0x31.
- Press 0x1C, press 0x32, release 0x1C (F0 1C) → putdown stays 1 with ps2_scanout=0x32. Then F0 32 → putdown=0.
- Send E0 75 (extended arrow) → ps2_scanout=0x75, ps2_out=0x00, putdown=1. Assert rst mid-frame → all outputs 0x00/0, and the next full frame decodes correctly.
- With PS2_TIMEOUT_EN defined: send 5 bits and stall > TIMEOUT_CYCLES, then a full 0x29 frame → ps2_out=0x20. Without the macro, the same stimulus yields a misaligned frame that is rejected, with no output change.
